// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse packet decoder.
// Flag bit positions follow the standard 3-byte PS/2 mouse packet layout.
package mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_FLAGS = 2'd0,
    WAIT_X     = 2'd1,
    WAIT_Y     = 2'd2,
    COMMIT     = 2'd3
  } state_t;

  localparam int BTN_LEFT = 0;
  localparam int SYNC     = 3;
  localparam int X_SIGN   = 4;
  localparam int X_OVF    = 6;

  localparam int DELTA_W  = 9;

endpackage

// File: rtl/mouse_x_accumulator.sv
// Combinational X update: forms the 9-bit signed delta and clamps mouse_x + delta to [0, X_MAX].
// No state, zero latency, no flow control.
module mouse_x_accumulator
  import mouse_pkg::*;
#(
  parameter logic [15:0] X_MAX = 16'd639
) (
  input  logic        x_sign,
  input  logic        x_ovf,
  input  logic [7:0]  x_byte,
  input  logic [15:0] cur_x,
  output logic [15:0] next_x
);

  localparam int SUM_W = 18;

  logic signed [DELTA_W-1:0] delta;
  logic signed [SUM_W-1:0]   sum;

  always_comb begin
    delta = {x_sign, x_byte};
    // An overflowed count saturates to the extreme of the 9-bit range.
    if (x_ovf) begin
      delta = x_sign ? {1'b1, 8'h00} : {1'b0, 8'hFF};
    end

    sum = $signed({2'b00, cur_x}) + $signed({{(SUM_W - DELTA_W){delta[DELTA_W-1]}}, delta});

    if (sum < 0) begin
      next_x = 16'd0;
    end else if (sum > $signed({2'b00, X_MAX})) begin
      next_x = X_MAX;
    end else begin
      next_x = sum[15:0];
    end
  end

endmodule

// File: rtl/mouse_packet_decoder.sv
// Decodes 3-byte mouse packets into an absolute clamped X position and left-button state.
// Outputs update one cycle after the Y byte is accepted; byte_ready drops only during the COMMIT cycle.
module mouse_packet_decoder
  import mouse_pkg::*;
#(
  parameter logic [15:0] X_MAX   = 16'd639,
  parameter int          TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mouse_pressed_,
  output logic [15:0] mouse_x,
  output logic        packet_error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic          btn_q;
  logic          sign_q;
  logic          ovf_q;
  logic [7:0]    x_q;
  logic [TW-1:0] timer;
  logic [15:0]   next_x;
  logic          accept;

  assign byte_ready = (state != COMMIT);
  assign accept     = byte_valid && byte_ready;

  mouse_x_accumulator #(
    .X_MAX (X_MAX)
  ) u_acc (
    .x_sign (sign_q),
    .x_ovf  (ovf_q),
    .x_byte (x_q),
    .cur_x  (mouse_x),
    .next_x (next_x)
  );

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state          <= WAIT_FLAGS;
      btn_q          <= 1'b0;
      sign_q         <= 1'b0;
      ovf_q          <= 1'b0;
      x_q            <= 8'd0;
      timer          <= '0;
      mouse_x        <= 16'd0;
      mouse_pressed_ <= 1'b1;
      packet_error   <= 1'b0;
    end else begin
      packet_error <= 1'b0;
      case (state)
        WAIT_FLAGS: begin
          timer <= '0;
          if (accept) begin
            if (byte_data[SYNC]) begin
              btn_q  <= byte_data[BTN_LEFT];
              sign_q <= byte_data[X_SIGN];
              ovf_q  <= byte_data[X_OVF];
              state  <= WAIT_X;
            end else begin
              packet_error <= 1'b1;
            end
          end
        end
        WAIT_X, WAIT_Y: begin
          if (accept) begin
            timer <= '0;
            if (state == WAIT_X) begin
              x_q   <= byte_data;
              state <= WAIT_Y;
            end else begin
              state <= COMMIT;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            // Idle budget spent: abandon the packet, outputs keep their old values.
            timer        <= '0;
            state        <= WAIT_FLAGS;
            packet_error <= 1'b1;
          end else if (timer != TW'(TIMEOUT)) begin
            timer <= timer + 1'b1;
          end
        end
        COMMIT: begin
          mouse_x        <= next_x;
          mouse_pressed_ <= ~btn_q;
          timer          <= '0;
          state          <= WAIT_FLAGS;
        end
        default: begin
          state <= WAIT_FLAGS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Directed self-checking bench for mouse_packet_decoder with hand-computed expectations.
module tb_mouse_packet_decoder;

  logic        clock;
  logic        reset_;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mouse_pressed_;
  logic [15:0] mouse_x;
  logic        packet_error;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  mouse_packet_decoder dut (
    .clock          (clock),
    .reset_         (reset_),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .mouse_pressed_ (mouse_pressed_),
    .mouse_x        (mouse_x),
    .packet_error   (packet_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (packet_error === 1'b1) err_pulses <= err_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("ready_before_accept", {31'd0, byte_ready}, 32'd1);
    @(posedge clock); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] f, input logic [7:0] x, input logic [7:0] y);
    send_byte(f);
    send_byte(x);
    send_byte(y);
    @(posedge clock); #1;
  endtask

  logic [7:0] bp_bytes [6];
  logic [7:0] ready_pattern;
  int         idx;
  logic       ready_before;

  initial begin
    reset_     = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("reset_mouse_x", {16'd0, mouse_x}, 32'd0);
    check("reset_pressed_n", {31'd0, mouse_pressed_}, 32'd1);
    check("reset_packet_error", {31'd0, packet_error}, 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    @(posedge clock); #1;
    check("ready_after_reset", {31'd0, byte_ready}, 32'd1);

    // Basic packet, with explicit latency check.
    send_byte(8'h09);
    send_byte(8'h0A);
    send_byte(8'h00);
    check("commit_ready_low", {31'd0, byte_ready}, 32'd0);
    check("commit_x_not_yet", {16'd0, mouse_x}, 32'd0);
    @(posedge clock); #1;
    check("basic_x", {16'd0, mouse_x}, 32'd10);
    check("basic_pressed_n", {31'd0, mouse_pressed_}, 32'd0);
    check("basic_ready_back", {31'd0, byte_ready}, 32'd1);

    // Negative deltas and low clamp.
    send_packet(8'h18, 8'hFB, 8'h00);
    check("neg5_x", {16'd0, mouse_x}, 32'd5);
    check("neg5_pressed_n", {31'd0, mouse_pressed_}, 32'd1);
    send_packet(8'h18, 8'hF6, 8'h00);
    check("low_clamp_x", {16'd0, mouse_x}, 32'd0);
    check("low_clamp_pressed_n", {31'd0, mouse_pressed_}, 32'd1);

    // Climb to 600, then overflow-positive clamps high, overflow-negative is -256.
    send_packet(8'h08, 8'hFF, 8'h00);
    check("plus255_x", {16'd0, mouse_x}, 32'd255);
    send_packet(8'h08, 8'hFF, 8'h00);
    send_packet(8'h08, 8'h5A, 8'h00);
    check("reach600_x", {16'd0, mouse_x}, 32'd600);
    send_packet(8'h48, 8'h00, 8'h00);
    check("high_clamp_x", {16'd0, mouse_x}, 32'd639);
    send_packet(8'h58, 8'h00, 8'h00);
    check("ovf_neg_x", {16'd0, mouse_x}, 32'd383);

    // Sync error: byte discarded, one error pulse, next packet still decodes.
    send_byte(8'h01);
    check("sync_err_pulse", {31'd0, packet_error}, 32'd1);
    check("sync_err_x_kept", {16'd0, mouse_x}, 32'd383);
    @(posedge clock); #1;
    check("sync_err_one_cycle", {31'd0, packet_error}, 32'd0);
    send_packet(8'h08, 8'h05, 8'h00);
    check("after_sync_x", {16'd0, mouse_x}, 32'd388);
    check("after_sync_pressed_n", {31'd0, mouse_pressed_}, 32'd1);
    check("sync_pulse_count", err_pulses, 32'd1);

    // Timeout: flags byte then 1023 idle cycles.
    send_byte(8'h08);
    repeat (1022) @(posedge clock);
    #1;
    check("timeout_not_early", {31'd0, packet_error}, 32'd0);
    @(posedge clock); #1;
    check("timeout_pulse", {31'd0, packet_error}, 32'd1);
    check("timeout_x_kept", {16'd0, mouse_x}, 32'd388);
    @(posedge clock); #1;
    check("timeout_one_cycle", {31'd0, packet_error}, 32'd0);
    send_packet(8'h09, 8'h03, 8'h00);
    check("after_timeout_x", {16'd0, mouse_x}, 32'd391);
    check("after_timeout_pressed_n", {31'd0, mouse_pressed_}, 32'd0);
    check("timeout_pulse_count", err_pulses, 32'd2);

    // Back-pressure: byte_valid held high over two back-to-back packets.
    bp_bytes[0] = 8'h08; bp_bytes[1] = 8'h01; bp_bytes[2] = 8'h00;
    bp_bytes[3] = 8'h09; bp_bytes[4] = 8'h02; bp_bytes[5] = 8'h00;
    idx = 0;
    ready_pattern = 8'h00;
    byte_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      byte_data = (idx < 6) ? bp_bytes[idx] : 8'h00;
      ready_before = byte_ready;
      ready_pattern[c] = ready_before;
      @(posedge clock); #1;
      if (ready_before) idx++;
    end
    byte_valid = 1'b0;
    check("bp_ready_pattern", {24'd0, ready_pattern}, 32'h77);
    check("bp_bytes_taken", idx, 32'd6);
    check("bp_x", {16'd0, mouse_x}, 32'd394);
    check("bp_pressed_n", {31'd0, mouse_pressed_}, 32'd0);

    // Reset after the X byte drops the packet quietly.
    send_byte(8'h08);
    send_byte(8'h10);
    reset_ = 1'b0;
    #1;
    check("rst_mid_x", {16'd0, mouse_x}, 32'd0);
    check("rst_mid_pressed_n", {31'd0, mouse_pressed_}, 32'd1);
    check("rst_mid_error", {31'd0, packet_error}, 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    @(posedge clock); #1;
    check("rst_mid_ready", {31'd0, byte_ready}, 32'd1);

    // Reset during COMMIT: no update survives.
    send_byte(8'h09);
    send_byte(8'h20);
    send_byte(8'h00);
    reset_ = 1'b0;
    #1;
    @(negedge clock);
    reset_ = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_commit_x", {16'd0, mouse_x}, 32'd0);
    check("rst_commit_pressed_n", {31'd0, mouse_pressed_}, 32'd1);
    check("rst_no_error_pulse", err_pulses, 32'd2);

    send_packet(8'h09, 8'h07, 8'h00);
    check("final_x", {16'd0, mouse_x}, 32'd7);
    check("final_pressed_n", {31'd0, mouse_pressed_}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
